// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
package sar_pkg;

    // Controller phases: waiting for a start request, or walking the trial bits.
    typedef enum logic {
        SAR_IDLE,
        SAR_CONV
    } sar_state_t;

    // Default resolution; must match the 'bits' parameter of the companion dac.
    localparam int SAR_DEFAULT_BITS = 8;

    // Width of the trial-bit pointer; a one-bit converter still needs one bit.
    function automatic int sarPtrWidth(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller. It drives the dac trial code, reads one
// comparator decision per clock, and presents the converted code after BITS trials.
// Code vectors are indexed MSB-first: index 0 carries weight 2^(BITS-1).
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int BITS = SAR_DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cmp,
    output logic [0:BITS-1] dac_code,
    output logic [0:BITS-1] data,
    output logic            valid,
    output logic            busy
);

    localparam int PTR_W = sarPtrWidth(BITS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BITS - 1);

    sar_state_t       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [0:BITS-1]  code_q;
    logic [0:BITS-1]  data_q;
    logic             valid_q;
    logic             busy_q;

    logic             cmpBit;
    logic [0:BITS-1]  decided_d;
    logic [0:BITS-1]  trial_d;

    // Resolve the bit under trial from the comparator and arm the next trial bit;
    // an unknown comparator level falls into the else path and clears the bit.
    always_comb begin
        cmpBit    = 1'b0;
        decided_d = code_q;
        trial_d   = code_q;
        if (cmp == 1'b1) begin
            cmpBit = 1'b1;
        end
        for (int i = 0; i < BITS; i++) begin
            if (PTR_W'(i) == ptr_q) begin
                decided_d[i] = cmpBit;
            end
        end
        trial_d = decided_d;
        if (ptr_q != LAST_PTR) begin
            for (int i = 0; i < BITS; i++) begin
                if (PTR_W'(i) == (ptr_q + PTR_W'(1))) begin
                    trial_d[i] = 1'b1;
                end
            end
        end
    end

    // Conversion sequencer: accepts start only when idle, steps one bit per clock,
    // and publishes the final code together with a single-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SAR_IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                SAR_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q   <= SAR_CONV;
                        busy_q    <= 1'b1;
                        ptr_q     <= '0;
                        code_q    <= '0;
                        code_q[0] <= 1'b1;
                    end
                end
                SAR_CONV: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= SAR_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        ptr_q   <= '0;
                        code_q  <= decided_d;
                        data_q  <= decided_d;
                    end else begin
                        ptr_q  <= ptr_q + PTR_W'(1);
                        code_q <= trial_d;
                    end
                end
                default: begin
                    state_q <= SAR_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign dac_code = code_q;
    assign data     = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Closed-loop bench for sar_adc_ctrl: an ideal dac/comparator pair is modelled with
// integer arithmetic (vin in units of 1/1024 of full scale, dac LSB = 4 units).
module tb_sar_adc_ctrl;

    localparam int BITS = 8;

    typedef struct {
        int vinUnits;
        int expData;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic            cmp;
    logic [0:BITS-1] dac_code;
    logic [0:BITS-1] data;
    logic            valid;
    logic            busy;

    int   vinUnits;
    int   total;
    int   bad;
    int   lastData;
    vec_t vectors[8];

    sar_adc_ctrl #(.BITS(BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp      (cmp),
        .dac_code (dac_code),
        .data     (data),
        .valid    (valid),
        .busy     (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ideal comparator: vin >= dac output, with dac output = code/256 of full scale.
    assign cmp = (vinUnits >= (int'(dac_code) * 4));

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Code the dac should show during trial k when the final result is res:
    // bits already decided copied from res, trial bit set, lower bits zero.
    function automatic int trialCode(input int res, input int k);
        int keepMask;
        keepMask = 255 & ~((1 << (BITS - k)) - 1);
        return (res & keepMask) | (1 << (BITS - 1 - k));
    endfunction

    // Runs one conversion from IDLE; optionally re-pulses start at trial glitchAt.
    task automatic applyStimulus(input int vin, input int expData, input int glitchAt);
        vinUnits = vin;
        start = 1'b1;
        for (int k = 0; k < BITS; k++) begin
            @(negedge clk);
            checkOutput("trial_code", int'(dac_code), trialCode(expData, k));
            checkOutput("busy_in_conv", int'(busy), 1);
            checkOutput("no_valid_in_conv", int'(valid), 0);
            checkOutput("data_held", int'(data), lastData);
            if (k == 0) start = 1'b0;
            if (glitchAt > 0 && k == glitchAt) start = 1'b1;
            if (glitchAt > 0 && k == glitchAt + 1) start = 1'b0;
        end
        @(negedge clk);
        checkOutput("valid_pulse", int'(valid), 1);
        checkOutput("busy_low_at_valid", int'(busy), 0);
        checkOutput("result", int'(data), expData);
        checkOutput("dac_holds_result", int'(dac_code), expData);
        lastData = expData;
        @(negedge clk);
        checkOutput("valid_one_cycle", int'(valid), 0);
        checkOutput("idle_after_conv", int'(busy), 0);
        checkOutput("dac_idle_hold", int'(dac_code), expData);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        lastData = 0;
        vinUnits = 0;
        start    = 1'b0;
        rst      = 1'b0;

        vectors[0] = '{512, 128};
        vectors[1] = '{0, 0};
        vectors[2] = '{1023, 255};
        vectors[3] = '{307, 76};
        vectors[4] = '{256, 64};
        vectors[5] = '{768, 192};
        vectors[6] = '{103, 25};
        vectors[7] = '{3, 0};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_dac", int'(dac_code), 0);
        checkOutput("reset_data", int'(data), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_no_start", int'(busy), 0);

        // Fixed vectors
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].vinUnits, vectors[i].expData, -1);
        end

        // Random inputs against floor(vin * 256)
        for (int i = 0; i < 16; i++) begin
            int v;
            v = int'($urandom_range(0, 1023));
            applyStimulus(v, v / 4, -1);
        end

        // Start re-pulsed during trial 3 is ignored
        applyStimulus(307, 76, 3);

        // Reset during trial 4 aborts with no valid pulse
        vinUnits = 512;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst = 1'b0;
        #1;
        checkOutput("abort_dac", int'(dac_code), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_valid", int'(valid), 0);
        checkOutput("abort_data", int'(data), 0);
        lastData = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("no_restart_after_abort", int'(busy), 0);
            checkOutput("no_valid_after_abort", int'(valid), 0);
        end
        applyStimulus(307, 76, -1);

        // Start held high: back-to-back conversions every 9 cycles
        vinUnits = 100;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            int expRes;
            int cycles;
            expRes = vinUnits / 4;
            cycles = 0;
            for (int k = 0; k < BITS; k++) begin
                @(negedge clk);
                cycles++;
                checkOutput("b2b_trial", int'(dac_code), trialCode(expRes, k));
                checkOutput("b2b_busy", int'(busy), 1);
            end
            @(negedge clk);
            cycles++;
            checkOutput("b2b_valid", int'(valid), 1);
            checkOutput("b2b_busy_gap", int'(busy), 0);
            checkOutput("b2b_result", int'(data), expRes);
            checkOutput("b2b_period", cycles, 9);
            lastData = expRes;
            if (c < 2) vinUnits = vinUnits + 300;
            else start = 1'b0;
        end
        @(negedge clk);
        checkOutput("b2b_stop_busy", int'(busy), 0);
        checkOutput("b2b_stop_valid", int'(valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
